// File: rtl/arb_burst_mux_pkg.sv
// rtl/arb_burst_mux_pkg.sv - shared state encoding and counter sizing for arb_burst_mux
package arb_burst_mux_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_REQ  = 4'b0010,
    ST_XFER = 4'b0100,
    ST_RLS  = 4'b1000
  } client_state_t;

  // Counters must be able to hold the larger of the two limits itself.
  function automatic int cnt_width(input int max_burst, input int timeout);
    int lim;
    lim = (max_burst > timeout) ? max_burst : timeout;
    return $clog2(lim + 1);
  endfunction

endpackage

// File: rtl/arb_client_fsm.sv
// rtl/arb_client_fsm.sv - per-client request/transfer/release FSM with beat and stall counters
module arb_client_fsm
  import arb_burst_mux_pkg::*;
#(
  parameter int MAX_BURST = 8,
  parameter int TIMEOUT   = 16,
  parameter int CW        = cnt_width(MAX_BURST, TIMEOUT)
) (
  input  logic clock,
  input  logic reset,
  input  logic valid,
  input  logic last,
  input  logic gnt,
  input  logic accept,
  output logic req,
  output logic in_xfer,
  output logic in_idle,
  output logic near_max
);

  localparam logic [CW-1:0] BEAT_LAST  = CW'(MAX_BURST - 1);
  localparam logic [CW-1:0] STALL_LAST = CW'(TIMEOUT - 1);

  client_state_t state;
  client_state_t state_nxt;
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] stall_cnt;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (valid) state_nxt = ST_REQ;
      ST_REQ:  if (gnt) state_nxt = ST_XFER;
      ST_XFER: begin
        if (accept && (last || beat_cnt == BEAT_LAST)) begin
          state_nxt = ST_RLS;
        end else if (!valid && stall_cnt == STALL_LAST) begin
          state_nxt = ST_RLS;
        end
      end
      // The arbiter keeps granting for a couple of cycles after req drops.
      ST_RLS:  if (!gnt) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      req       <= 1'b0;
      beat_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      req   <= (state_nxt == ST_REQ) || (state_nxt == ST_XFER);

      if (state_nxt == ST_XFER && state != ST_XFER) begin
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + CW'(1);
      end

      // Backpressure keeps valid high, so it never counts as a stall.
      if (state == ST_XFER && !valid) begin
        stall_cnt <= stall_cnt + CW'(1);
      end else begin
        stall_cnt <= '0;
      end
    end
  end

  assign in_xfer  = (state == ST_XFER);
  assign in_idle  = (state == ST_IDLE);
  assign near_max = (beat_cnt == BEAT_LAST);

endmodule

// File: rtl/arb_burst_mux.sv
// rtl/arb_burst_mux.sv - steers one granted client burst onto the shared downstream port
module arb_burst_mux
  import arb_burst_mux_pkg::*;
#(
  parameter int DW        = 32,
  parameter int MAX_BURST = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          c0_valid,
  input  logic [DW-1:0] c0_data,
  input  logic          c0_last,
  output logic          c0_ready,
  input  logic          c1_valid,
  input  logic [DW-1:0] c1_data,
  input  logic          c1_last,
  output logic          c1_ready,
  output logic          req_0,
  output logic          req_1,
  input  logic          gnt_0,
  input  logic          gnt_1,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          m_src,
  input  logic          m_ready,
  output logic          err
);

  logic xfer_0, xfer_1;
  logic idle_0, idle_1;
  logic near_max_0, near_max_1;
  logic gnt_clash;
  logic own_0, own_1;
  logic accept_0, accept_1;

  // A double grant is a protocol violation; nobody owns the port that cycle.
  assign gnt_clash = gnt_0 & gnt_1;
  assign own_0     = xfer_0 & gnt_0 & ~gnt_clash;
  assign own_1     = xfer_1 & gnt_1 & ~gnt_clash;

  assign c0_ready  = m_ready & own_0;
  assign c1_ready  = m_ready & own_1;
  assign accept_0  = own_0 & c0_valid & m_ready;
  assign accept_1  = own_1 & c1_valid & m_ready;

  arb_client_fsm #(
    .MAX_BURST (MAX_BURST),
    .TIMEOUT   (TIMEOUT)
  ) u_fsm_0 (
    .clock    (clock),
    .reset    (reset),
    .valid    (c0_valid),
    .last     (c0_last),
    .gnt      (gnt_0),
    .accept   (accept_0),
    .req      (req_0),
    .in_xfer  (xfer_0),
    .in_idle  (idle_0),
    .near_max (near_max_0)
  );

  arb_client_fsm #(
    .MAX_BURST (MAX_BURST),
    .TIMEOUT   (TIMEOUT)
  ) u_fsm_1 (
    .clock    (clock),
    .reset    (reset),
    .valid    (c1_valid),
    .last     (c1_last),
    .gnt      (gnt_1),
    .accept   (accept_1),
    .req      (req_1),
    .in_xfer  (xfer_1),
    .in_idle  (idle_1),
    .near_max (near_max_1)
  );

  always_comb begin
    m_valid = 1'b0;
    m_data  = '0;
    m_last  = 1'b0;
    m_src   = 1'b0;
    if (own_0) begin
      m_valid = c0_valid;
      m_data  = c0_data;
      m_last  = c0_last | near_max_0;
    end else if (own_1) begin
      m_valid = c1_valid;
      m_data  = c1_data;
      m_last  = c1_last | near_max_1;
      m_src   = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err <= 1'b0;
    end else if (gnt_clash || (gnt_0 && idle_0) || (gnt_1 && idle_1)) begin
      err <= 1'b1;
    end
  end

endmodule
